if_thread_fetch: RTL
====================

# if_thread_fetch

Instruction-fetch PC generator for the 4-thread interleaved CPU. It holds one 10-bit PC and one active bit per thread, and selects one thread per cycle in round-robin order. It drives that thread's PC to instruction memory and the IF/ID pipeline register, then advances that PC. Sits directly upstream of the IF/ID register and accepts thread start/halt commands and branch redirects from later stages.

## Interface
- No parameters; thread count fixed at 4, PC width fixed at 10.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  advance enable; shared with the IF/ID register enable; low = stall
- thread_start  in  1  activate thread start_tid at start_pc
- start_tid  in  2  thread to start
- start_pc  in  10  initial PC for started thread
- thread_halt  in  1  deactivate thread halt_tid
- halt_tid  in  2  thread to halt
- br_taken  in  1  branch redirect strobe
- br_tid  in  2  thread being redirected
- br_target  in  10  redirect target PC
- IF_pc  out  10  PC of selected thread; to imem address and IF/ID
- IF_tid  out  2  selected thread id; to IF/ID
- IF_valid  out  1  selected thread is active
- active_mask  out  4  per-thread active bits

## Operation
- State: pc[0..3] (10 b each), active[3:0], cur_tid (2 b).
- Outputs are combinational from state: IF_tid = cur_tid, IF_pc = pc[cur_tid], IF_valid = active[cur_tid], active_mask = active.
- Reset: all pc = 0, active = 4'b0001, cur_tid = 0. This gives IF_pc = 0, IF_tid = 0, IF_valid = 1, active_mask = 4'b0001.
- en=1 edge:
  - if IF_valid, pc[cur_tid] <= pc[cur_tid] + 1, mod 1024 (1023 wraps to 0);
  - cur_tid <= next thread (see Configuration).
- en=0: cur_tid and PC increment held.
- start, halt and branch updates apply regardless of en; redirects are never dropped during a stall.
- thread_start: active[start_tid] <= 1, pc[start_tid] <= start_pc.
- thread_halt: active[halt_tid] <= 0; PC retained.
- br_taken: pc[br_tid] <= br_target; active bit unchanged.
- Per-thread PC write priority on one edge: start > branch > increment.
- Start and halt on the same tid in one cycle: start wins (active = 1).
- Halt of cur_tid on the same edge as its fetch: the increment still applies; the thread is skipped thereafter.

## Timing
- Zero-latency output: IF_pc/IF_tid are valid in the cycle cur_tid is selected and are captured by IF/ID on the same edge (en=1).
- Start, halt or branch strobed in cycle N takes effect in state at edge N. The new PC is visible on IF_pc the next time that thread is selected, at earliest cycle N+1.
- Fixed rotation: each thread is selected exactly every 4 enabled cycles.
- A branch to the thread being fetched in the same cycle: that cycle's IF_pc is the old PC. Later stages flush it by tid.

## Configuration
- IF_SKIP_IDLE_EN undefined: cur_tid <= cur_tid + 1 mod 4, regardless of active. Inactive slots produce IF_valid = 0 bubbles.
- IF_SKIP_IDLE_EN defined: cur_tid <= first thread in circular order cur_tid+1, +2, +3, cur_tid whose next-state active bit is 1. Next-state means after this edge's start/halt.
  - If no thread is active, cur_tid <= cur_tid + 1 mod 4.
  - A single active thread is selected every cycle.

## Test plan
- Reset, en=1 for 8 cycles, no commands -> IF_tid 0,1,2,3,0,1,2,3. IF_valid 1,0,0,0,1,0,0,0. IF_pc at tid 0 = 0 then 1. Under IF_SKIP_IDLE_EN: IF_tid = 0 every cycle, IF_pc 0..7.
- Start tid 2 at 0x100 in cycle 0 -> active_mask = 4'b0101. Thread 2 fetches 0x100 on its next slot, then 0x101 four cycles later (fixed rotation).
- pc[0] at 1023, thread 0 fetched -> next fetch of thread 0 shows IF_pc = 0.
- br_taken tid 0 target 0x2A in the same cycle thread 0 fetches 0x005 -> IF_pc = 0x005 that cycle, 0x2A at the next thread-0 slot (not 0x006).
- en=0 for 3 cycles with br_taken tid 1 target 0x3FF in stall cycle 2 -> IF_pc/IF_tid frozen during the stall. Thread 1 later fetches 0x3FF.
- Same-cycle thread_start and thread_halt on tid 3 -> active[3] = 1. Then halt of the only active thread under IF_SKIP_IDLE_EN -> mask 0; cur_tid rotates and IF_valid = 0.

Source files
------------

// File: rtl/if_thread_fetch.sv
// Round-robin PC generator for the 4-thread interleaved fetch stage.
// Define IF_SKIP_IDLE_EN to skip inactive threads when choosing the next slot.
module if_thread_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       thread_start,
  input  logic [1:0] start_tid,
  input  logic [9:0] start_pc,
  input  logic       thread_halt,
  input  logic [1:0] halt_tid,
  input  logic       br_taken,
  input  logic [1:0] br_tid,
  input  logic [9:0] br_target,
  output logic [9:0] IF_pc,
  output logic [1:0] IF_tid,
  output logic       IF_valid,
  output logic [3:0] active_mask
);

  logic [9:0] pc [4];
  logic [3:0] active;
  logic [3:0] active_nx;
  logic [1:0] cur_tid;
  logic [1:0] tid_nx;

  assign IF_tid      = cur_tid;
  assign IF_pc       = pc[cur_tid];
  assign IF_valid    = active[cur_tid];
  assign active_mask = active;

  // Start is applied after halt so it wins on a shared tid.
  always_comb begin
    active_nx = active;
    if (thread_halt)
      active_nx[halt_tid] = 1'b0;
    if (thread_start)
      active_nx[start_tid] = 1'b1;
  end

`ifdef IF_SKIP_IDLE_EN
  logic       found;
  logic [1:0] cand;

  // k = 4 wraps back to cur_tid, so a lone thread keeps its slot.
  always_comb begin
    tid_nx = cur_tid + 2'd1;
    found  = 1'b0;
    cand   = cur_tid;
    for (int k = 1; k <= 4; k++) begin
      cand = cur_tid + 2'(k);
      if (!found && active_nx[cand]) begin
        tid_nx = cand;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    tid_nx = cur_tid + 2'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        pc[i] <= 10'd0;
      active  <= 4'b0001;
      cur_tid <= 2'd0;
    end else begin
      active <= active_nx;
      if (en)
        cur_tid <= tid_nx;
      for (int i = 0; i < 4; i++) begin
        if (thread_start && start_tid == 2'(i))
          pc[i] <= start_pc;
        else if (br_taken && br_tid == 2'(i))
          pc[i] <= br_target;
        else if (en && IF_valid && cur_tid == 2'(i))
          pc[i] <= pc[i] + 10'd1;
      end
    end
  end

endmodule
